// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, RV32I opcode/funct fields and the issue-stage op record.
// Used by the issue stage and by the ALU itself.
package alu_pkg;

  typedef enum logic [3:0] {
    AND = 4'd0,
    OR  = 4'd1,
    XOR = 4'd2,
    ADD = 4'd3,
    SUB = 4'd4,
    SLL = 4'd5,
    SRL = 4'd6,
    SRA = 4'd7,
    SLT = 4'd8,
    NOP = 4'd15
  } alu_ctl_e;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_ctl_e        ctl;
    logic [4:0]      rd;
    logic            illegal;
  } issue_op_t;

  localparam issue_op_t OP_RESET = '{a: 32'd0, b: 32'd0, ctl: AND, rd: 5'd0, illegal: 1'b0};

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

  // Base mapping only; SUB/SRA are selected by funct7 in the decoder.
  function automatic alu_ctl_e f3_ctl(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ADD;
      F3_SLL:  return SLL;
      F3_SLT:  return SLT;
      F3_XOR:  return XOR;
      F3_SR:   return SRL;
      F3_OR:   return OR;
      F3_AND:  return AND;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Handshake and operand bundle between the instruction source, the issue stage and the ALU.
// master = source/consumer side, slave = the issue stage.
interface alu_issue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [3:0]            alu_ctl;
  logic [4:0]            rd;
  logic                  illegal;
  logic [CNT_WIDTH-1:0]  illegal_cnt;

  modport master (
    output in_valid, instr, rs1_val, rs2_val, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_ctl, rd, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, instr, rs1_val, rs2_val, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_ctl, rd, illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I OP/OP-IMM decoder producing ALU control, operands and destination.
// Illegal or unsupported encodings collapse to NOP with zero operands.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] rs1_val,
  input  logic [DATA_WIDTH-1:0] rs2_val,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output alu_ctl_e              ctl,
  output logic [4:0]            rd,
  output logic                  illegal
);

  logic [6:0]            opcode_s;
  logic [2:0]            funct3_s;
  logic [6:0]            funct7_s;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] b_s;
  alu_ctl_e              ctl_s;
  logic                  legal_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign imm_s    = sext12(instr[31:20]);

  // Field decode; ctl_s/b_s are only meaningful when legal_s is set.
  always_comb begin
    ctl_s   = NOP;
    b_s     = {DATA_WIDTH{1'b0}};
    legal_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        case (funct3_s)
          F3_ADD: begin
            b_s     = rs2_val;
            ctl_s   = (funct7_s == F7_ALT) ? SUB : ADD;
            legal_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
          end
          F3_SLL: begin
            // The ALU shifts by all of b, so only the low 5 bits may survive.
            b_s     = {{(DATA_WIDTH-5){1'b0}}, rs2_val[4:0]};
            ctl_s   = SLL;
            legal_s = (funct7_s == F7_BASE);
          end
          F3_SR: begin
            b_s     = {{(DATA_WIDTH-5){1'b0}}, rs2_val[4:0]};
            ctl_s   = (funct7_s == F7_ALT) ? SRA : SRL;
            legal_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
          end
          F3_SLT, F3_XOR, F3_OR, F3_AND: begin
            b_s     = rs2_val;
            ctl_s   = f3_ctl(funct3_s);
            legal_s = (funct7_s == F7_BASE);
          end
          default: begin
            legal_s = 1'b0;
          end
        endcase
      end
      OPC_OPIMM: begin
        case (funct3_s)
          F3_SLL: begin
            b_s     = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
            ctl_s   = SLL;
            legal_s = (funct7_s == F7_BASE);
          end
          F3_SR: begin
            b_s     = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
            ctl_s   = (funct7_s == F7_ALT) ? SRA : SRL;
            legal_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
          end
          F3_ADD, F3_SLT, F3_XOR, F3_OR, F3_AND: begin
            b_s     = imm_s;
            ctl_s   = f3_ctl(funct3_s);
            legal_s = 1'b1;
          end
          default: begin
            legal_s = 1'b0;
          end
        endcase
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  assign a       = legal_s ? rs1_val : {DATA_WIDTH{1'b0}};
  assign b       = legal_s ? b_s : {DATA_WIDTH{1'b0}};
  assign ctl     = legal_s ? ctl_s : NOP;
  assign illegal = !legal_s;
  assign rd      = instr[11:7];

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes OP/OP-IMM, registers the result behind an optional skid entry
// so in_ready and all ALU-side outputs come straight from flops; counts illegal ops.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit SKID_EN    = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.slave bus
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("alu_issue: DATA_WIDTH must be 32");
  end

  issue_op_t             dec_op_s;
  issue_op_t             out_op_r, out_op_n;
  issue_op_t             skid_op_r, skid_op_n;
  logic                  out_valid_r, out_valid_n;
  logic                  skid_valid_r, skid_valid_n;
  logic                  in_ready_r, in_ready_n;
  logic                  in_ready_s, in_fire_s, out_fire_s;
  logic [CNT_WIDTH-1:0]  cnt_r, cnt_n;
  logic [DATA_WIDTH-1:0] dec_a_s, dec_b_s;
  alu_ctl_e              dec_ctl_s;
  logic [4:0]            dec_rd_s;
  logic                  dec_illegal_s;

  alu_op_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .instr   (bus.instr),
    .rs1_val (bus.rs1_val),
    .rs2_val (bus.rs2_val),
    .a       (dec_a_s),
    .b       (dec_b_s),
    .ctl     (dec_ctl_s),
    .rd      (dec_rd_s),
    .illegal (dec_illegal_s)
  );

  assign dec_op_s = '{a: dec_a_s, b: dec_b_s, ctl: dec_ctl_s, rd: dec_rd_s, illegal: dec_illegal_s};

  // Without the skid entry, ready must look through to the consumer combinationally.
  assign in_ready_s = SKID_EN ? in_ready_r : (!out_valid_r || bus.out_ready);
  assign in_fire_s  = bus.in_valid && in_ready_s;
  assign out_fire_s = out_valid_r && bus.out_ready;

  // Next-state for output register, skid entry, registered ready and illegal counter.
  always_comb begin
    out_valid_n  = out_valid_r;
    out_op_n     = out_op_r;
    skid_valid_n = skid_valid_r;
    skid_op_n    = skid_op_r;
    cnt_n        = cnt_r;
    if (!out_valid_r || out_fire_s) begin
      if (skid_valid_r) begin
        out_op_n     = skid_op_r;
        out_valid_n  = 1'b1;
        skid_valid_n = 1'b0;
      end else if (in_fire_s) begin
        out_op_n    = dec_op_s;
        out_valid_n = 1'b1;
      end else begin
        out_valid_n = 1'b0;
      end
    end else begin
      if (in_fire_s) begin
        skid_op_n    = dec_op_s;
        skid_valid_n = 1'b1;
      end else begin
        skid_valid_n = skid_valid_r;
      end
    end
    if (in_fire_s && dec_op_s.illegal && (cnt_r != {CNT_WIDTH{1'b1}})) begin
      cnt_n = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_n = cnt_r;
    end
    in_ready_n = !skid_valid_n;
  end

  // State registers; reset discards any in-flight ops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_op_r     <= OP_RESET;
      skid_valid_r <= 1'b0;
      skid_op_r    <= OP_RESET;
      in_ready_r   <= 1'b0;
      cnt_r        <= {CNT_WIDTH{1'b0}};
    end else begin
      out_valid_r  <= out_valid_n;
      out_op_r     <= out_op_n;
      skid_valid_r <= skid_valid_n;
      skid_op_r    <= skid_op_n;
      in_ready_r   <= in_ready_n;
      cnt_r        <= cnt_n;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.alu_a       = out_op_r.a;
  assign bus.alu_b       = out_op_r.b;
  assign bus.alu_ctl     = out_op_r.ctl;
  assign bus.rd          = out_op_r.rd;
  assign bus.illegal     = out_op_r.illegal;
  assign bus.illegal_cnt = cnt_r;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, illegal counting/saturation, skid backpressure, reset.
module tb_alu_issue;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) ifc ();
  alu_issue_if #(.DATA_WIDTH(32), .CNT_WIDTH(2))  ifc2 ();

  alu_issue #(.DATA_WIDTH(32), .SKID_EN(1'b1), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
  );
  alu_issue #(.DATA_WIDTH(32), .SKID_EN(1'b0), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(ifc2.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [74:0] exp;

  // {out_valid, alu_ctl, rd, illegal, alu_a, alu_b}
  function automatic logic [74:0] snap();
    return {ifc.out_valid, ifc.alu_ctl, ifc.rd, ifc.illegal, ifc.alu_a, ifc.alu_b};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
    ifc.in_valid = v;
    ifc.instr    = i;
    ifc.rs1_val  = r1;
    ifc.rs2_val  = r2;
  endtask

  task automatic test_reset();
    #12;
    exp = 75'd0;
    checks++; if (snap() !== exp) begin errors++; $display("FAIL reset_outputs got %h want %h", snap(), exp); end
    checks++; if (ifc.illegal_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %h want 0", ifc.illegal_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ifc.in_ready); end
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ifc.out_valid); end
  endtask

  task automatic test_add();
    ifc.out_ready = 1'b1;
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
    cyc();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    exp = {1'b1, 4'd3, 5'd3, 1'b0, 32'd5, 32'd7};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL add got %h want %h", snap(), exp); end
    cyc();
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b want 0", ifc.out_valid); end
  endtask

  task automatic test_sub_imm();
    drive(1'b1, 32'h407302B3, 32'd20, 32'd8);
    cyc();
    exp = {1'b1, 4'd4, 5'd5, 1'b0, 32'd20, 32'd8};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL sub got %h want %h", snap(), exp); end
    drive(1'b1, 32'hFFF00093, 32'd0, 32'h1234);
    cyc();
    exp = {1'b1, 4'd3, 5'd1, 1'b0, 32'd0, 32'hFFFFFFFF};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL addi_sext got %h want %h", snap(), exp); end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    cyc();
  endtask

  task automatic test_shift();
    logic [31:0] sll_i;
    logic [31:0] srl_i;
    sll_i = {7'b0000000, 5'd2, 5'd1, 3'b001, 5'd4, 7'b0110011};
    srl_i = {7'b0000000, 5'd3, 5'd1, 3'b101, 5'd6, 7'b0110011};
    drive(1'b1, 32'h4040D113, 32'h80000000, 32'h99);
    cyc();
    exp = {1'b1, 4'd7, 5'd2, 1'b0, 32'h80000000, 32'd4};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL srai got %h want %h", snap(), exp); end
    drive(1'b1, sll_i, 32'h11, 32'h25);
    cyc();
    exp = {1'b1, 4'd5, 5'd4, 1'b0, 32'h11, 32'd5};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL sll_mask got %h want %h", snap(), exp); end
    drive(1'b1, srl_i, 32'hF0, 32'hFFFFFFE3);
    cyc();
    exp = {1'b1, 4'd6, 5'd6, 1'b0, 32'hF0, 32'd3};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL srl_mask got %h want %h", snap(), exp); end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    cyc();
  endtask

  task automatic test_illegal();
    logic [31:0] mul_i;
    logic [31:0] slli_i;
    logic [31:0] add0_i;
    mul_i  = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd2, 7'b0110011};
    slli_i = {7'b0100000, 5'd3, 5'd1, 3'b001, 5'd7, 7'b0010011};
    add0_i = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0, 7'b0110011};
    drive(1'b1, 32'h003130B3, 32'h55, 32'h66);
    cyc();
    exp = {1'b1, 4'd15, 5'd1, 1'b1, 32'd0, 32'd0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL sltu got %h want %h", snap(), exp); end
    checks++; if (ifc.illegal_cnt !== 16'd1) begin errors++; $display("FAIL cnt_sltu got %0d want 1", ifc.illegal_cnt); end
    drive(1'b1, 32'h0000007F, 32'd1, 32'd2);
    cyc();
    exp = {1'b1, 4'd15, 5'd0, 1'b1, 32'd0, 32'd0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL bad_opcode got %h want %h", snap(), exp); end
    drive(1'b1, mul_i, 32'd3, 32'd4);
    cyc();
    exp = {1'b1, 4'd15, 5'd2, 1'b1, 32'd0, 32'd0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL bad_funct7 got %h want %h", snap(), exp); end
    drive(1'b1, slli_i, 32'd3, 32'd4);
    cyc();
    exp = {1'b1, 4'd15, 5'd7, 1'b1, 32'd0, 32'd0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL bad_slli got %h want %h", snap(), exp); end
    checks++; if (ifc.illegal_cnt !== 16'd4) begin errors++; $display("FAIL cnt_four got %0d want 4", ifc.illegal_cnt); end
    drive(1'b1, add0_i, 32'd2, 32'd3);
    cyc();
    exp = {1'b1, 4'd3, 5'd0, 1'b0, 32'd2, 32'd3};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL add_rd0 got %h want %h", snap(), exp); end
    checks++; if (ifc.illegal_cnt !== 16'd4) begin errors++; $display("FAIL cnt_hold got %0d want 4", ifc.illegal_cnt); end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    cyc();
  endtask

  task automatic test_saturate();
    logic [1:0] want;
    ifc2.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifc2.in_valid = 1'b1;
      ifc2.instr    = 32'h003130B3;
      cyc();
      want = (i < 3) ? 2'(i + 1) : 2'd3;
      checks++; if (ifc2.illegal_cnt !== want) begin errors++; $display("FAIL sat_cnt_%0d got %0d want %0d", i, ifc2.illegal_cnt, want); end
    end
    ifc2.in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [74:0] op1, op2, op3;
    op1 = {1'b1, 4'd3, 5'd3, 1'b0, 32'd1, 32'd2};
    op2 = {1'b1, 4'd4, 5'd5, 1'b0, 32'd10, 32'd3};
    op3 = {1'b1, 4'd3, 5'd1, 1'b0, 32'd100, 32'hFFFFFFFF};
    ifc.out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'd1, 32'd2);
    cyc();
    checks++; if (snap() !== op1) begin errors++; $display("FAIL bp_op1 got %h want %h", snap(), op1); end
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b want 1", ifc.in_ready); end
    drive(1'b1, 32'h407302B3, 32'd10, 32'd3);
    cyc();
    checks++; if (snap() !== op1) begin errors++; $display("FAIL bp_hold1 got %h want %h", snap(), op1); end
    checks++; if (ifc.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got %b want 0", ifc.in_ready); end
    drive(1'b1, 32'hFFF00093, 32'd100, 32'd0);
    cyc();
    cyc();
    checks++; if (snap() !== op1) begin errors++; $display("FAIL bp_hold2 got %h want %h", snap(), op1); end
    checks++; if (ifc.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_stall got %b want 0", ifc.in_ready); end
    ifc.out_ready = 1'b1;
    cyc();
    checks++; if (snap() !== op2) begin errors++; $display("FAIL bp_op2 got %h want %h", snap(), op2); end
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b want 1", ifc.in_ready); end
    cyc();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    checks++; if (snap() !== op3) begin errors++; $display("FAIL bp_op3 got %h want %h", snap(), op3); end
    cyc();
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", ifc.out_valid); end
  endtask

  task automatic test_reset_mid();
    ifc.out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'd9, 32'd9);
    cyc();
    drive(1'b1, 32'h407302B3, 32'd8, 32'd8);
    cyc();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    checks++; if (ifc.in_ready !== 1'b0) begin errors++; $display("FAIL mid_skid_full got %b want 0", ifc.in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    exp = 75'd0;
    checks++; if (snap() !== exp) begin errors++; $display("FAIL mid_async got %h want %h", snap(), exp); end
    checks++; if (ifc.illegal_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", ifc.illegal_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", ifc.in_ready); end
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", ifc.out_valid); end
    ifc.out_ready = 1'b1;
    cyc();
    cyc();
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got %b want 0", ifc.out_valid); end
  endtask

  initial begin
    rst_n          = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.instr      = 32'h0;
    ifc.rs1_val    = 32'h0;
    ifc.rs2_val    = 32'h0;
    ifc.out_ready  = 1'b0;
    ifc2.in_valid  = 1'b0;
    ifc2.instr     = 32'h0;
    ifc2.rs1_val   = 32'h0;
    ifc2.rs2_val   = 32'h0;
    ifc2.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_imm();
    test_shift();
    test_illegal();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage driving the `alu` control/operand interface. It is the producer end of the ALU's `ctl`/`a`/`b` inputs.
- Accepts an RV32I OP / OP-IMM instruction plus register operands on a valid/ready handshake.
- Decodes the instruction into the 4-bit ALU control code and the two operands.
- Presents the result through a registered output stage with a skid buffer, so both directions of backpressure are fully registered. Keeps a saturating count of illegal instructions.

Parameters:
- DATA_WIDTH, 32, operand width; only 32 is legal (elaboration-time check).
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with in_ready = !out_valid | out_ready.
- CNT_WIDTH, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  instruction/operands valid
- in_ready  out  1  stage can accept
- instr  in  32  RV32I instruction word
- rs1_val  in  DATA_WIDTH  rs1 register value
- rs2_val  in  DATA_WIDTH  rs2 register value
- out_valid  out  1  decoded op valid
- out_ready  in  1  ALU/writeback can accept
- alu_a  out  DATA_WIDTH  ALU operand a
- alu_b  out  DATA_WIDTH  ALU operand b
- alu_ctl  out  4  ALU control code
- rd  out  5  destination register index
- illegal  out  1  decoded op is illegal/unsupported
- illegal_cnt  out  CNT_WIDTH  saturating count of accepted illegal ops

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values: out_valid=0, alu_a=0, alu_b=0, alu_ctl=0, rd=0, illegal=0, illegal_cnt=0, skid entry empty. in_ready=1 from the first edge after reset release.
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- Latency: 1 cycle. An accepted op appears on the outputs the next cycle when the output register is empty or draining.
- Output ordering: strictly in order; no op is dropped or duplicated.
- Output stability: while out_valid=1 and out_ready=0, all outputs hold stable.
- Skid buffer (SKID_EN=1):
  - in_ready = !skid_full, registered.
  - If the output register is stalled and an input arrives, the input goes to skid and in_ready drops the next cycle.
  - When the output drains, skid moves to the output register and in_ready returns the next cycle.
  - Simultaneous input and output transfer with skid empty: the output register loads the new op directly; skid stays empty.
- Decode by opcode instr[6:0]:
  - OP (0110011): a=rs1_val, b=rs2_val for arithmetic/logic ops.
  - OP-IMM (0010011): a=rs1_val, b=sign-extended instr[31:20].
- funct3 to alu_ctl mapping:
  - 000 → ADD=3. For OP, funct7=0100000 gives SUB=4.
  - 001 → SLL=5.
  - 010 → SLT=8.
  - 100 → XOR=2.
  - 101 → SRL=6 (funct7=0000000) or SRA=7 (funct7=0100000).
  - 110 → OR=1.
  - 111 → AND=0.
- Shift operands:
  - OP shifts: b = {27'b0, rs2_val[4:0]}. Masking is required because the ALU shifts by the full b.
  - OP-IMM shifts: b = {27'b0, instr[24:20]}.
- Illegal cases, each with illegal=1:
  - Any other opcode.
  - funct3=011 (SLTU/SLTIU; the ALU has no unsigned compare).
  - OP with funct7 not 0000000, or not 0100000 for funct3 000/101.
  - OP-IMM SLLI with funct7≠0000000.
  - OP-IMM SRLI/SRAI with funct7 not 0000000/0100000.
- Illegal op output: alu_ctl=15 (ALU outputs 0), alu_a=alu_b=0, rd=instr[11:7]. The op still passes through the handshake.
- illegal_cnt: increments by 1 on each input transfer of an illegal op. Saturates at all-ones and never wraps.
- rd=0 is legal and is passed through unchanged.
- Reset mid-operation: all in-flight ops (output register and skid) are discarded immediately, and the counter clears.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_ctl_e: AND=0, OR=1, XOR=2, ADD=3, SUB=4, SLL=5, SRL=6, SRA=7, SLT=8, NOP=15.
  - Opcode constants OPC_OP, OPC_OPIMM.
  - funct3 constants and funct7 constants F7_BASE, F7_ALT.
- This package is shared with `alu`.
- Sub-module: alu_op_decode, purely combinational (instr, rs1_val, rs2_val → a, b, ctl, rd, illegal). alu_issue wraps it with the handshake, skid buffer and counter.

Test Plan:
- ADD: instr=0x002081B3, rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, alu_ctl=3, a=5, b=7, rd=3, illegal=0.
- SUB and sign-extension:
  - instr=0x407302B3 → alu_ctl=4, rd=5.
  - Then ADDI 0xFFF00093 with rs1=0 → alu_ctl=3, b=0xFFFFFFFF, rd=1.
- Shifts:
  - SRAI 0x4040D113 → alu_ctl=7, b=4, rd=2.
  - SLL (funct7=0, funct3=001) with rs2=0x25 → alu_ctl=5, b=5.
- Illegal: SLTU 0x003130B3 → illegal=1, alu_ctl=15, a=b=0, rd=1, illegal_cnt 0→1. With CNT_WIDTH=2, 5 illegal ops → illegal_cnt stays 3.
- Backpressure:
  - Hold out_ready=0 and stream 3 ops back-to-back → op1 is held stable on the output, op2 sits in skid, in_ready=0 from the cycle after op2 is accepted, op3 is stalled.
  - Release out_ready → op1, op2, op3 emerge in order on consecutive cycles, with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with skid full → outputs go to their reset values asynchronously. After release, in_ready=1, out_valid=0, and no stale op appears.
